// File: rtl/inst_assembler.sv
// RV32I program loader: encodes symbolic instruction descriptors, range-checks
// their immediates and writes the machine words to consecutive IROM addresses.
module inst_assembler #(
    parameter int ADDR_W    = 14,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic              op_valid_i,
    output logic              op_ready_o,
    input  logic [4:0]        op_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [31:0]       imm_i,
    input  logic              last_i,
    output logic              wen_o,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [31:0]       wdata_o,
    input  logic              wack_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [ADDR_W:0]   count_o
);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE, S_ERR} state_t;

    localparam logic [6:0]      OPC_R    = 7'b0110011;
    localparam logic [6:0]      OPC_I    = 7'b0010011;
    localparam logic [6:0]      OPC_LW   = 7'b0000011;
    localparam logic [6:0]      OPC_JALR = 7'b1100111;
    localparam logic [6:0]      OPC_S    = 7'b0100011;
    localparam logic [6:0]      OPC_B    = 7'b1100011;
    localparam logic [6:0]      OPC_U    = 7'b0110111;
    localparam logic [6:0]      OPC_J    = 7'b1101111;
    localparam logic [6:0]      F7_ALT   = 7'b0100000;
    localparam logic [ADDR_W:0] FULL     = {1'b1, {ADDR_W{1'b0}}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d, waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              last_q, last_d;

    logic [31:0] enc_word;
    logic        enc_illegal, enc_range;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        imm_i_ok, imm_sh_ok, imm_b_ok, imm_j_ok, imm_u_ok;

    // R-type funct3, indexed by op 0..7
    function automatic logic [2:0] r_f3(input logic [2:0] sel);
        case (sel)
            3'd2:       r_f3 = 3'b111;
            3'd3:       r_f3 = 3'b110;
            3'd4:       r_f3 = 3'b100;
            3'd5:       r_f3 = 3'b001;
            3'd6, 3'd7: r_f3 = 3'b101;
            default:    r_f3 = 3'b000;
        endcase
    endfunction

    // I-ALU funct3 for addi/andi/ori/xori, indexed by op-8
    function automatic logic [2:0] i_f3(input logic [1:0] sel);
        case (sel)
            2'd1:    i_f3 = 3'b111;
            2'd2:    i_f3 = 3'b110;
            2'd3:    i_f3 = 3'b100;
            default: i_f3 = 3'b000;
        endcase
    endfunction

    // Branch funct3 for beq/bne/blt/bge, indexed by op-18
    function automatic logic [2:0] b_f3(input logic [1:0] sel);
        case (sel)
            2'd1:    b_f3 = 3'b001;
            2'd2:    b_f3 = 3'b100;
            2'd3:    b_f3 = 3'b101;
            default: b_f3 = 3'b000;
        endcase
    endfunction

    // An immediate fits a signed field when every bit above the field matches its sign
    assign imm_i_ok  = (imm_i[31:11] == '0) || (imm_i[31:11] == '1);
    assign imm_sh_ok = (imm_i[31:5] == '0);
    assign imm_b_ok  = !imm_i[0] && ((imm_i[31:12] == '0) || (imm_i[31:12] == '1));
    assign imm_j_ok  = !imm_i[0] && ((imm_i[31:20] == '0) || (imm_i[31:20] == '1));
    assign imm_u_ok  = (imm_i[11:0] == '0);

    always_comb begin
        enc_word    = 32'd0;
        enc_illegal = 1'b0;
        enc_range   = 1'b0;
        f3          = 3'b000;
        f7          = 7'd0;
        case (op_i)
            5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7: begin
                f3       = r_f3(op_i[2:0]);
                f7       = (op_i == 5'd1 || op_i == 5'd7) ? F7_ALT : 7'd0;
                enc_word = {f7, rs2_i, rs1_i, f3, rd_i, OPC_R};
            end
            5'd8, 5'd9, 5'd10, 5'd11: begin
                f3        = i_f3(op_i[1:0]);
                enc_range = !imm_i_ok;
                enc_word  = {imm_i[11:0], rs1_i, f3, rd_i, OPC_I};
            end
            5'd12, 5'd13, 5'd14: begin
                f3        = (op_i == 5'd12) ? 3'b001 : 3'b101;
                f7        = (op_i == 5'd14) ? F7_ALT : 7'd0;
                enc_range = !imm_sh_ok;
                enc_word  = {f7, imm_i[4:0], rs1_i, f3, rd_i, OPC_I};
            end
            5'd15: begin
                enc_range = !imm_i_ok;
                enc_word  = {imm_i[11:0], rs1_i, 3'b010, rd_i, OPC_LW};
            end
            5'd16: begin
                enc_range = !imm_i_ok;
                enc_word  = {imm_i[11:0], rs1_i, 3'b000, rd_i, OPC_JALR};
            end
            5'd17: begin
                enc_range = !imm_i_ok;
                enc_word  = {imm_i[11:5], rs2_i, rs1_i, 3'b010, imm_i[4:0], OPC_S};
            end
            5'd18, 5'd19, 5'd20, 5'd21: begin
                f3        = b_f3(op_i[1:0] - 2'd2);
                enc_range = !imm_b_ok;
                enc_word  = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, f3,
                             imm_i[4:1], imm_i[11], OPC_B};
            end
            5'd22: begin
                enc_range = !imm_u_ok;
                enc_word  = {imm_i[31:12], rd_i, OPC_U};
            end
            5'd23: begin
                enc_range = !imm_j_ok;
                enc_word  = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_J};
            end
            default: enc_illegal = 1'b1;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_code_d = err_code_q;
        last_d     = last_q;
        case (state_q)
            S_LOAD: begin
                if (op_valid_i) begin
                    if (enc_illegal) begin
                        err_code_d = 2'b01;
                        state_d    = S_ERR;
                    end else if (enc_range) begin
                        err_code_d = 2'b10;
                        state_d    = S_ERR;
                    end else begin
                        wdata_d = enc_word;
                        waddr_d = ptr_q;
                        last_d  = last_i;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wack_i) begin
                    ptr_d   = ptr_q + ADDR_W'(1);
                    count_d = count_q + (ADDR_W + 1)'(1);
                    // A final word that exactly fills memory still completes the load
                    if (last_q) begin
                        state_d = S_DONE;
                    end else if (count_d == FULL) begin
                        err_code_d = 2'b11;
                        state_d    = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            default: begin
                if (start_i) begin
                    ptr_d      = ADDR_W'(BASE_ADDR);
                    count_d    = '0;
                    err_code_d = 2'b00;
                    state_d    = S_LOAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            ptr_q      <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            err_code_q <= 2'b00;
            last_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
            last_q     <= last_d;
        end
    end

    assign op_ready_o = (state_q == S_LOAD);
    assign wen_o      = (state_q == S_WRITE);
    assign busy_o     = (state_q == S_LOAD) || (state_q == S_WRITE);
    assign done_o     = (state_q == S_DONE);
    assign err_o      = (state_q == S_ERR);
    assign err_code_o = err_code_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_inst_assembler.sv
// Bench for inst_assembler: directed program loads, error paths, a 2-bit
// address instance for memory-full, and randomized descriptors vs a reference encoder.
module tb_inst_assembler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, op_valid = 1'b0, last = 1'b0, wack = 1'b0;
    logic [4:0]  op = '0, rd = '0, rs1 = '0, rs2 = '0;
    logic [31:0] imm = '0;
    logic        op_ready, wen, busy, done, err;
    logic [13:0] waddr;
    logic [31:0] wdata;
    logic [1:0]  err_code;
    logic [14:0] count;

    logic        s_start = 1'b0, s_valid = 1'b0, s_wack = 1'b0;
    logic        s_ready, s_wen, s_busy, s_done, s_err;
    logic [1:0]  s_waddr, s_code;
    logic [31:0] s_wdata;
    logic [2:0]  s_count;

    int total = 0;
    int passed = 0;

    always #5 clk = ~clk;

    inst_assembler dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .op_valid_i(op_valid),
        .op_ready_o(op_ready), .op_i(op), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
        .imm_i(imm), .last_i(last), .wen_o(wen), .waddr_o(waddr), .wdata_o(wdata),
        .wack_i(wack), .busy_o(busy), .done_o(done), .err_o(err),
        .err_code_o(err_code), .count_o(count)
    );

    inst_assembler #(.ADDR_W(2), .BASE_ADDR(0)) dut_small (
        .clk_i(clk), .rst_i(rst), .start_i(s_start), .op_valid_i(s_valid),
        .op_ready_o(s_ready), .op_i(5'd8), .rd_i(5'd1), .rs1_i(5'd0), .rs2_i(5'd0),
        .imm_i(32'd1), .last_i(1'b0), .wen_o(s_wen), .waddr_o(s_waddr),
        .wdata_o(s_wdata), .wack_i(s_wack), .busy_o(s_busy), .done_o(s_done),
        .err_o(s_err), .err_code_o(s_code), .count_o(s_count)
    );

    localparam logic [2:0] R_F3 [8] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd5};
    localparam logic [2:0] I_F3 [4] = '{3'd0, 3'd7, 3'd6, 3'd4};
    localparam logic [2:0] B_F3 [4] = '{3'd0, 3'd1, 3'd4, 3'd5};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    // Reference encoder: formats by op range, legality by signed numeric range
    function automatic void ref_encode(input logic [4:0] o5, input logic [4:0] d, s1, s2,
                                       input logic [31:0] im,
                                       output logic [31:0] w, output logic [1:0] code);
        int o;
        longint s;
        o = int'(o5);
        s = longint'($signed(im));
        w = 32'd0;
        code = 2'b00;
        if (o >= 24) begin
            code = 2'b01;
        end else if (o <= 7) begin
            w = {(o == 1 || o == 7) ? 7'b0100000 : 7'b0, s2, s1, R_F3[o], d, 7'b0110011};
        end else if (o <= 11 || o == 15 || o == 16) begin
            if (s < -2048 || s > 2047) code = 2'b10;
            if (o == 15)      w = {im[11:0], s1, 3'd2, d, 7'b0000011};
            else if (o == 16) w = {im[11:0], s1, 3'd0, d, 7'b1100111};
            else              w = {im[11:0], s1, I_F3[o-8], d, 7'b0010011};
        end else if (o <= 14) begin
            if (im > 32'd31) code = 2'b10;
            w = {(o == 14) ? 7'b0100000 : 7'b0, im[4:0], s1, (o == 12) ? 3'd1 : 3'd5, d, 7'b0010011};
        end else if (o == 17) begin
            if (s < -2048 || s > 2047) code = 2'b10;
            w = {im[11:5], s2, s1, 3'd2, im[4:0], 7'b0100011};
        end else if (o <= 21) begin
            if (s < -4096 || s > 4094 || (s % 2) != 0) code = 2'b10;
            w = {im[12], im[10:5], s2, s1, B_F3[o-18], im[4:1], im[11], 7'b1100011};
        end else if (o == 22) begin
            if ((im % 32'd4096) != 0) code = 2'b10;
            w = {im[31:12], d, 7'b0110111};
        end else begin
            if (s < -(64'sd1 <<< 20) || s > (64'sd1 <<< 20) - 2 || (s % 2) != 0) code = 2'b10;
            w = {im[20], im[10:1], im[11], im[19:12], d, 7'b1101111};
        end
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
    endtask

    task automatic send(input logic [4:0] o, input logic [4:0] d, s1, s2,
                        input logic [31:0] im, input logic l);
        int n;
        n = 0;
        while (!op_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("op_ready_before_send", op_ready, 1);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im; last = l;
        op_valid = 1'b1;
        @(posedge clk); #1 op_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack(input logic [13:0] ea, input logic [31:0] ed, input int delay);
        for (int k = 0; k <= delay; k++) begin
            check("wen", wen, 1);
            check("waddr", waddr, ea);
            check("wdata", wdata, ed);
            check("op_ready_in_write", op_ready, 0);
            if (k < delay) @(negedge clk);
        end
        wack = 1'b1;
        @(posedge clk); #1 wack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] ew, rimm;
        logic [1:0]  ec;
        logic [4:0]  rop;
        int          ptr, k;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", op_ready, 0);
        check("rst_wen", wen, 0);
        check("rst_waddr", waddr, 0);
        check("rst_wdata", wdata, 0);
        check("rst_flags", {busy, done, err, err_code}, 0);
        check("rst_count", count, 0);
        check("rst_small", {s_ready, s_wen, s_count, s_code}, 0);

        // Basic three-instruction program
        pulse_start();
        check("busy_load", busy, 1);
        send(5'd8, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        ack(14'd0, 32'h00500093, 0);
        check("ready_n2", op_ready, 1);
        send(5'd0, 5'd3, 5'd1, 5'd2, 32'd0, 1'b0);
        ack(14'd1, 32'h002081B3, 0);
        send(5'd1, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1);
        ack(14'd2, 32'h402081B3, 0);
        check("done", done, 1);
        check("done_busy", busy, 0);
        check("done_count", count, 3);

        // Other formats, with a stalled write on the second word
        pulse_start();
        check("restart_count", count, 0);
        send(5'd17, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0);
        ack(14'd0, 32'h0020A423, 0);
        send(5'd18, 5'd0, 5'd1, 5'd2, -32'sd4, 1'b0);
        ack(14'd1, 32'hFE208EE3, 5);
        send(5'd23, 5'd1, 5'd0, 5'd0, 32'd8, 1'b0);
        ack(14'd2, 32'h008000EF, 0);
        send(5'd22, 5'd5, 5'd0, 5'd0, 32'h12345000, 1'b0);
        ack(14'd3, 32'h123452B7, 0);
        send(5'd14, 5'd1, 5'd1, 5'd0, 32'd3, 1'b1);
        ack(14'd4, 32'h4030D093, 0);
        check("done2_count", count, 5);

        // Error paths
        pulse_start();
        send(5'd25, 5'd1, 5'd1, 5'd1, 32'd0, 1'b0);
        check("illegal_err", {err, err_code}, {1'b1, 2'b01});
        check("illegal_nowen", wen, 0);
        pulse_start();
        check("clear1", {err, err_code, count}, 0);
        send(5'd8, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0);
        check("addi_range", {err, err_code, wen}, {1'b1, 2'b10, 1'b0});
        pulse_start();
        check("clear2", {err, err_code, count}, 0);
        send(5'd18, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0);
        check("beq_range", {err, err_code, wen}, {1'b1, 2'b10, 1'b0});
        pulse_start();
        check("clear3", {err, err_code, count}, 0);

        // Memory-full on a 4-word instance
        s_start = 1'b1;
        @(posedge clk); #1 s_start = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("small_ready", s_ready, (i < 4) ? 1 : 0);
            if (i < 4) begin
                s_valid = 1'b1;
                @(posedge clk); #1 s_valid = 1'b0;
                @(negedge clk);
                check("small_wen", s_wen, 1);
                check("small_waddr", s_waddr, i);
                s_wack = 1'b1;
                @(posedge clk); #1 s_wack = 1'b0;
                @(negedge clk);
            end
        end
        check("small_full", {s_err, s_code, s_wen}, {1'b1, 2'b11, 1'b0});
        check("small_count", s_count, 4);

        // Randomized descriptors against the reference encoder
        ptr = 0;
        for (int t = 0; t < 80; t++) begin
            rop  = 5'($urandom_range(0, 27));
            rimm = $urandom;
            k    = $urandom_range(3, 23);
            rimm = 32'($signed(rimm) >>> (32 - k));
            if ($urandom_range(0, 2) != 0) rimm[0] = 1'b0;
            if (rop == 5'd22 && $urandom_range(0, 3) != 0) rimm = $urandom & 32'hFFFFF000;
            if (rop >= 5'd12 && rop <= 5'd14 && $urandom_range(0, 2) != 0) rimm = 32'($urandom_range(0, 31));
            rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
            ref_encode(rop, rd, rs1, rs2, rimm, ew, ec);
            send(rop, rd, rs1, rs2, rimm, 1'b0);
            if (ec == 2'b00) begin
                ack(14'(ptr), ew, $urandom_range(0, 2));
                ptr++;
                check("rand_count", count, ptr);
            end else begin
                check("rand_err", {err, err_code, wen}, {1'b1, ec, 1'b0});
                pulse_start();
                ptr = 0;
            end
        end
        send(5'd8, 5'd0, 5'd0, 5'd0, 32'd0, 1'b1);
        ack(14'(ptr), 32'h00000013, 0);
        check("rand_done", {done, count}, {1'b1, 15'(ptr + 1)});

        // Reset in the middle of a write
        pulse_start();
        send(5'd8, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0);
        ack(14'd0, 32'h00500093, 0);
        send(5'd3, 5'd7, 5'd6, 5'd5, 32'd0, 1'b0);
        check("pre_rst_wen", wen, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outputs", {op_ready, wen, waddr, wdata, busy, done, err, err_code, count}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {op_ready, busy}, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
